// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer for the single-port word data memory.
// Byte-addressed byte/half/word requests are turned into word accesses;
// sub-word stores use read-modify-write, loads are extended to 32 bits.
`timescale 1ns/1ps
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 12,
    parameter bit          RR_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [1:0]  p0_size,
    input  logic        p0_unsigned,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_ack,
    output logic        p0_err,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [1:0]  p1_size,
    input  logic        p1_unsigned,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_ack,
    output logic        p1_err,
    output logic [31:0] p1_rdata,
    output logic        mem_write_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

    state_t      state;
    logic        grant;
    logic        last_grant;
    logic        l_we;
    logic [1:0]  l_size;
    logic        l_unsigned;
    logic [1:0]  l_lane;

    logic        any_req;
    logic        sel;
    logic        s_we;
    logic [1:0]  s_size;
    logic        s_unsigned;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic        s_bad;
    logic        unused_addr;

    // Extract the addressed lane of a memory word and extend it.
    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] lane,
                                             input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = w >> {lane, 3'b000};
        case (size)
            2'b00:   return uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return w;
        endcase
    endfunction

    // Replace the addressed byte/half lane of the old word with store data.
    function automatic logic [31:0] merge_lane(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [1:0] lane, input logic [1:0] size);
        logic [31:0] m;
        m = old;
        if (size == 2'b00)
            m[{lane, 3'b000} +: 8] = wd[7:0];
        else
            m[{lane[1], 4'b0000} +: 16] = wd[15:0];
        return m;
    endfunction

    // Pick the port to serve and check its request for alignment/size errors.
    always_comb begin
        any_req = p0_req | p1_req;
        if (p0_req && p1_req)
            sel = RR_EN ? ~last_grant : 1'b0;
        else
            sel = p1_req;
        s_we       = sel ? p1_we       : p0_we;
        s_size     = sel ? p1_size     : p0_size;
        s_unsigned = sel ? p1_unsigned : p0_unsigned;
        s_addr     = sel ? p1_addr     : p0_addr;
        s_wdata    = sel ? p1_wdata    : p0_wdata;
        s_bad      = (s_size == 2'b11) ||
                     (s_size == 2'b01 && s_addr[0]) ||
                     (s_size == 2'b10 && s_addr[1:0] != 2'b00);
    end

    // Address bits above the memory size are ignored (addresses wrap).
    assign unused_addr = ^s_addr[31:ADDR_W+2];

    // Transaction sequencer with registered memory and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            grant          <= 1'b0;
            last_grant     <= 1'b1;
            l_we           <= 1'b0;
            l_size         <= '0;
            l_unsigned     <= 1'b0;
            l_lane         <= '0;
            p0_ack         <= 1'b0;
            p0_err         <= 1'b0;
            p0_rdata       <= '0;
            p1_ack         <= 1'b0;
            p1_err         <= 1'b0;
            p1_rdata       <= '0;
            mem_write_en   <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant      <= sel;
                        last_grant <= sel;
                        l_we       <= s_we;
                        l_size     <= s_size;
                        l_unsigned <= s_unsigned;
                        l_lane     <= s_addr[1:0];
                        if (s_bad) begin
                            state  <= RESP;
                            p0_ack <= ~sel;
                            p1_ack <= sel;
                            p0_err <= ~sel;
                            p1_err <= sel;
                        end else begin
                            state          <= ACCESS;
                            mem_addr       <= {{(32-ADDR_W){1'b0}}, s_addr[ADDR_W+1:2]};
                            mem_write_en   <= s_we && (s_size == 2'b10);
                            mem_write_data <= s_wdata;
                        end
                    end
                end
                ACCESS: begin
                    mem_write_en <= 1'b0;
                    if (l_we && l_size != 2'b10) begin
                        // Sub-word store: old word is on mem_read_data now; write merged word next.
                        mem_write_data <= merge_lane(mem_read_data, mem_write_data, l_lane, l_size);
                        mem_write_en   <= 1'b1;
                        state          <= WRITE;
                    end else begin
                        state    <= RESP;
                        p0_ack   <= ~grant;
                        p1_ack   <= grant;
                        p0_rdata <= (!grant && !l_we) ? load_ext(mem_read_data, l_lane, l_size, l_unsigned) : '0;
                        p1_rdata <= (grant && !l_we)  ? load_ext(mem_read_data, l_lane, l_size, l_unsigned) : '0;
                    end
                end
                WRITE: begin
                    mem_write_en <= 1'b0;
                    p0_ack       <= ~grant;
                    p1_ack       <= grant;
                    state        <= RESP;
                end
                RESP: begin
                    p0_ack   <= 1'b0;
                    p0_err   <= 1'b0;
                    p0_rdata <= '0;
                    p1_ack   <= 1'b0;
                    p1_err   <= 1'b0;
                    p1_rdata <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter with a behavioural data_mem.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam logic [31:0] FP_WORD = 32'h5A5A_0F0F;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p0_unsigned, p0_ack, p0_err;
    logic [1:0]  p0_size;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic        p1_req, p1_we, p1_unsigned, p1_ack, p1_err;
    logic [1:0]  p1_size;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic        mem_write_en;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;

    logic        f0_req, f1_req, f0_ack, f1_ack, f0_err, f1_err, f_mem_write_en;
    logic [31:0] f0_rdata, f1_rdata, f_mem_addr, f_mem_write_data;

    logic [31:0] mem [0:4095];
    exp_t        sbq[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          wen_cnt = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(12), .RR_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_unsigned(p0_unsigned),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_unsigned(p1_unsigned),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mem_write_en(mem_write_en), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    dmem_arbiter #(.ADDR_W(12), .RR_EN(1'b0)) u_fp (
        .clk(clk), .rst(rst),
        .p0_req(f0_req), .p0_we(1'b0), .p0_size(2'b10), .p0_unsigned(1'b0),
        .p0_addr(32'h0), .p0_wdata(32'h0), .p0_ack(f0_ack), .p0_err(f0_err), .p0_rdata(f0_rdata),
        .p1_req(f1_req), .p1_we(1'b0), .p1_size(2'b10), .p1_unsigned(1'b0),
        .p1_addr(32'h4), .p1_wdata(32'h0), .p1_ack(f1_ack), .p1_err(f1_err), .p1_rdata(f1_rdata),
        .mem_write_en(f_mem_write_en), .mem_addr(f_mem_addr), .mem_write_data(f_mem_write_data),
        .mem_read_data(FP_WORD)
    );

    // data_mem: negedge write, negedge-registered read
    always @(negedge clk) begin
        if (mem_write_en) mem[mem_addr[11:0]] <= mem_write_data;
        mem_read_data <= mem[mem_addr[11:0]];
        if (mem_write_en) wen_cnt <= wen_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every ack must match the oldest expected response
    always @(negedge clk) begin
        if (!rst && (p0_ack || p1_ack)) begin
            if (sbq.size() == 0) begin
                check("unexpected_ack", {30'h0, p0_ack, p1_ack}, 32'h0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("sb_port", {30'h0, p0_ack, p1_ack}, e.port ? 32'h1 : 32'h2);
                check("sb_rdata", e.port ? p1_rdata : p0_rdata, e.rdata);
                check("sb_err", {31'h0, e.port ? p1_err : p0_err}, {31'h0, e.err});
            end
        end
    end

    task automatic do_req(input string tag, input bit port, input bit we, input logic [1:0] size,
                          input bit uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input bit exp_err, input int lat,
                          input int exp_wen, input bit push);
        int n;
        int w0;
        bit got;
        exp_t e;
        if (push) begin
            e.port = port; e.rdata = exp_rdata; e.err = exp_err;
            sbq.push_back(e);
        end
        w0 = wen_cnt;
        if (!port) begin
            p0_we = we; p0_size = size; p0_unsigned = uns; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
        end else begin
            p1_we = we; p1_size = size; p1_unsigned = uns; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
        end
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            got = port ? p1_ack : p0_ack;
        end
        check({tag, "_ack_seen"}, {31'h0, got}, 32'h1);
        if (lat > 0) check({tag, "_latency"}, n - 1, lat);
        if (exp_wen >= 0) check({tag, "_wen_pulses"}, wen_cnt - w0, exp_wen);
        @(posedge clk);
        #1;
        if (!port) p0_req = 1'b0; else p1_req = 1'b0;
    endtask

    task automatic f_wait(output logic [1:0] acks);
        int n;
        n = 0;
        acks = 2'b00;
        while (acks == 2'b00 && n < 40) begin
            @(negedge clk);
            n++;
            acks = {f0_ack, f1_ack};
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        logic [1:0] acks;
        rst = 1'b1;
        p0_req = 0; p0_we = 0; p0_size = 0; p0_unsigned = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_size = 0; p1_unsigned = 0; p1_addr = 0; p1_wdata = 0;
        f0_req = 0; f1_req = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_p0_ack", {31'h0, p0_ack}, 32'h0);
        check("rst_p1_ack", {31'h0, p1_ack}, 32'h0);
        check("rst_p0_rdata", p0_rdata, 32'h0);
        check("rst_mem_we", {31'h0, mem_write_en}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_write_data, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_req("st_w10", 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 1, 1);
        do_req("ld_w10", 0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2, 0, 1);
        check("ld_w10_mem_addr", mem_addr, 32'h4);
        do_req("ld_wrap", 0, 0, 2'b10, 0, 32'h4010, 32'h0, 32'hDEADBEEF, 0, 2, 0, 1);
        check("wrap_mem_addr", mem_addr, 32'h4);

        do_req("st_w20", 0, 1, 2'b10, 0, 32'h20, 32'h11223344, 32'h0, 0, 2, 1, 1);
        do_req("st_b21", 0, 1, 2'b00, 0, 32'h21, 32'h000000AA, 32'h0, 0, 3, 1, 1);
        do_req("ld_w20a", 0, 0, 2'b10, 0, 32'h20, 32'h0, 32'h1122AA44, 0, 2, 0, 1);
        do_req("st_h22", 0, 1, 2'b01, 0, 32'h22, 32'h0000BEEF, 32'h0, 0, 3, 1, 1);
        do_req("ld_w20b", 0, 0, 2'b10, 0, 32'h20, 32'h0, 32'hBEEFAA44, 0, 2, 0, 1);

        do_req("st_w30", 0, 1, 2'b10, 0, 32'h30, 32'h80FF7F01, 32'h0, 0, 2, 1, 1);
        do_req("ld_b33s", 0, 0, 2'b00, 0, 32'h33, 32'h0, 32'hFFFFFF80, 0, 2, 0, 1);
        do_req("ld_b33u", 0, 0, 2'b00, 1, 32'h33, 32'h0, 32'h00000080, 0, 2, 0, 1);
        do_req("ld_h30s", 0, 0, 2'b01, 0, 32'h30, 32'h0, 32'h00007F01, 0, 2, 0, 1);
        do_req("ld_h32s", 0, 0, 2'b01, 0, 32'h32, 32'h0, 32'hFFFF80FF, 0, 2, 0, 1);
        do_req("ld_b32u", 0, 0, 2'b00, 1, 32'h32, 32'h0, 32'h000000FF, 0, 2, 0, 1);

        do_req("err_h31", 0, 0, 2'b01, 0, 32'h31, 32'h0, 32'h0, 1, 1, 0, 1);
        do_req("err_w22", 0, 1, 2'b10, 0, 32'h22, 32'h12345678, 32'h0, 1, 1, 0, 1);
        do_req("err_sz3", 0, 0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1, 1, 0, 1);
        do_req("ld_w20c", 0, 0, 2'b10, 0, 32'h20, 32'h0, 32'hBEEFAA44, 0, 2, 0, 1);

        // Round robin: p1 granted last, so ties go p0 then p1
        do_req("p1_ld20", 1, 0, 2'b10, 0, 32'h20, 32'h0, 32'hBEEFAA44, 0, 2, 0, 1);
        for (int r = 0; r < 2; r++) begin
            sbq.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
            sbq.push_back('{1'b1, 32'hBEEFAA44, 1'b0});
            fork
                do_req("tie_p0", 0, 0, 2'b10, 0, 32'h10, 32'h0, 32'h0, 0, 0, -1, 0);
                do_req("tie_p1", 1, 0, 2'b10, 0, 32'h20, 32'h0, 32'h0, 0, 0, -1, 0);
            join
        end
        // After a lone p0 grant a tie goes to p1 first
        do_req("p0_ld30", 0, 0, 2'b10, 0, 32'h30, 32'h0, 32'h80FF7F01, 0, 2, 0, 1);
        sbq.push_back('{1'b1, 32'hBEEFAA44, 1'b0});
        sbq.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
        fork
            do_req("rr_p0", 0, 0, 2'b10, 0, 32'h10, 32'h0, 32'h0, 0, 0, -1, 0);
            do_req("rr_p1", 1, 0, 2'b10, 0, 32'h20, 32'h0, 32'h0, 0, 0, -1, 0);
        join

        // Reset while a load is in ACCESS: abandoned with no ack
        p0_we = 0; p0_size = 2'b10; p0_unsigned = 0; p0_addr = 32'h10; p0_req = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        p0_req = 1'b0;
        check("mid_rst_p0_ack", {31'h0, p0_ack}, 32'h0);
        check("mid_rst_mem_addr", mem_addr, 32'h0);
        check("mid_rst_mem_we", {31'h0, mem_write_en}, 32'h0);
        check("mid_rst_p0_rdata", p0_rdata, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mid_rst_no_ack", {30'h0, p0_ack, p1_ack}, 32'h0);
        end
        @(posedge clk);
        #1;
        do_req("post_rst_p1", 1, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2, 0, 1);

        // Fixed priority instance: p0 wins a tie even right after its own grant
        f0_req = 1'b1;
        f_wait(acks);
        check("fp_single", {30'h0, acks}, 32'h2);
        check("fp_single_rdata", f0_rdata, FP_WORD);
        @(posedge clk);
        #1;
        f0_req = 1'b0;
        f0_req = 1'b1;
        f1_req = 1'b1;
        f_wait(acks);
        check("fp_tie_first", {30'h0, acks}, 32'h2);
        @(posedge clk);
        #1;
        f0_req = 1'b0;
        f_wait(acks);
        check("fp_tie_second", {30'h0, acks}, 32'h1);
        check("fp_tie_second_rdata", f1_rdata, FP_WORD);
        @(posedge clk);
        #1;
        f1_req = 1'b0;

        repeat (3) @(posedge clk);
        check("sb_drained", sbq.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester controller that sequences and shares the single-port word data memory (data_mem, 4096 x 32-bit, negedge-registered read, negedge write) between the CPU load/store path (port 0) and the loader/debug path (port 1).
- Converts byte-addressed byte/half/word loads and stores into word accesses.
- Sub-word stores are done as read-modify-write.
- Loads are extended to 32 bits. Misaligned requests are rejected.

Parameters:
- ADDR_W, 12, word-index width driven to memory (4096 words = 16 KB).
- RR_EN, 1, 1 = round-robin between ports on simultaneous requests; 0 = fixed priority, port 0 wins.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  synchronous, active-high reset.
- pN_req  input  1  request valid, N in {0,1}; held with its fields until pN_ack.
- pN_we  input  1  1 = store, 0 = load.
- pN_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- pN_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- pN_addr  input  32  byte address.
- pN_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- pN_ack  output  1  one-cycle completion pulse.
- pN_err  output  1  valid with ack; 1 = misaligned or illegal size, no memory access done.
- pN_rdata  output  32  load result, valid with ack; 0 for stores and errors.
- mem_write_en  output  1  to data_mem write_en.
- mem_addr  output  32  word index, zero-extended: pN_addr[ADDR_W+1:2].
- mem_write_data  output  32  to data_mem write_data.
- mem_read_data  input  32  from data_mem read_data.

Behaviour:
- Reset
  - state = IDLE.
  - All outputs 0.
  - Round-robin pointer last_grant = 1, so port 0 wins the first tie.
  - Reset mid-transaction abandons it with no ack. A write already in progress in that cycle's negedge may complete; the bench must not rely on it.
- Memory timing
  - mem_addr and mem_write_en are driven from registers updated at posedge.
  - data_mem captures at the following negedge, so mem_read_data is sampled at the next posedge (same cycle).
- State: IDLE
  - At posedge, if any pN_req, select a port:
    - Only one requesting: grant it.
    - Both requesting, RR_EN=1: grant the port != last_grant.
    - Both requesting, RR_EN=0: grant port 0.
  - Latch we, size, unsigned, addr, wdata; update last_grant.
  - Error check: size=11, or half with addr[0]=1, or word with addr[1:0]!=0 → go to RESP with err=1.
  - Otherwise → ACCESS.
- State: ACCESS
  - mem_addr = latched word index.
  - mem_write_en = 1 only for a word store, with mem_write_data = wdata.
  - Loads: capture mem_read_data, extract the lane, extend it → RESP.
  - Word store → RESP.
  - Sub-word store: capture mem_read_data → WRITE.
- State: WRITE
  - mem_write_en = 1.
  - mem_write_data = captured word with the target lane replaced:
    - byte k = addr[1:0] occupies bits [8k+7:8k];
    - half h = addr[1] occupies bits [16h+15:16h].
  - Little-endian; all other lanes are unchanged. → RESP.
- State: RESP
  - Granted pN_ack = 1 for exactly one cycle, with pN_rdata and pN_err.
  - Ungranted port's ack stays 0. → IDLE.
- Latency from the accepting posedge to ack high:
  - Loads and word stores: 2 cycles.
  - Sub-word stores: 3 cycles.
  - Errors: 1 cycle.
- Throughput: requester must drop req, or present a new request, in the cycle after ack. IDLE re-samples req. Back-to-back requests from one port cost one idle cycle between them.
- A request arriving during a busy transaction waits. Its request fields may not change until its ack.
- mem_write_en is never high in IDLE or RESP.
- Address bits above ADDR_W+1 are ignored, so addresses wrap modulo 16 KB.

Test Plan:
- p0 word store addr 0x10, wdata 0xDEADBEEF, then word load at 0x10 → store ack 2 cycles after accept; load rdata = 0xDEADBEEF, err = 0; mem_addr = 4.
- Word 0x11223344 at 0x20, then byte store 0xAA at 0x21 → RMW; word reads 0x1122AA44; ack 3 cycles after accept; exactly one mem_write_en pulse on the RMW.
- Word 0x80FF7F01 at 0x30:
  - byte load 0x33, signed → 0xFFFFFF80;
  - same load, unsigned → 0x00000080;
  - half load 0x30, signed → 0x00007F01.
- p0 and p1 req asserted in the same cycle, repeatedly, RR_EN=1 → grants alternate p0, p1, p0, ...; with RR_EN=0, p0 is always granted first.
- Half load at 0x31 and word store at 0x22 → ack after 1 cycle, err = 1, rdata = 0, mem_write_en never asserted; memory unchanged.
- rst asserted in ACCESS of a load → next cycle state IDLE, all outputs 0, no ack; a following p1 load completes normally.
